nf10_axis_pkt_gen: RTL and testbench

Parametrised, synthesisable AXI4-Stream Ethernet frame generator: the productised successor of the hand-written converter stimulus. It emits configurable-length frames (DA/SA/EtherType header, incrementing-byte payload) at any supported data width. Frame count and inter-frame gap are programmable, and the generator obeys full tready backpressure. It sits in front of width converters or the datapath for bring-up and loopback tests.

---
 rtl/nf10_axis_pkt_gen_pkg.sv | 33 +++
 rtl/nf10_axis_pkt_gen_lanes.sv | 31 +++
 rtl/nf10_axis_pkt_gen.sv | 174 +++++++++++++++++
 tb/tb_nf10_axis_pkt_gen.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nf10_axis_pkt_gen_pkg.sv
// Shared types, constants and the frame byte function for the AXI4-Stream frame generator.
package nf10_axis_pkt_gen_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSend = 2'd1,
        StGap  = 2'd2
    } state_e;

    localparam int unsigned MinFrameLen = 60;
    localparam int unsigned HdrLen      = 14;

    // Byte k of a frame, ignoring the length limit: DA, SA, EtherType, then a payload byte.
    function automatic logic [7:0] frame_byte(input int unsigned k,
                                              input logic [47:0] da,
                                              input logic [47:0] sa,
                                              input logic [15:0] et);
        logic [7:0] b;
        if (k < 6) begin
            b = 8'(da >> (8 * (5 - k)));
        end else if (k < 12) begin
            b = 8'(sa >> (8 * (11 - k)));
        end else if (k == 12) begin
            b = et[15:8];
        end else if (k == 13) begin
            b = et[7:0];
        end else begin
            b = 8'(k - HdrLen);
        end
        return b;
    endfunction

endpackage

// File: rtl/nf10_axis_pkt_gen_lanes.sv
// Combinational byte-lane generator: builds tdata/tstrb for the beat starting at a byte offset.
module nf10_axis_pkt_gen_lanes
    import nf10_axis_pkt_gen_pkg::*;
#(
    parameter int unsigned C_M_AXIS_DATA_WIDTH = 64,
    parameter int unsigned C_LEN_WIDTH         = 16
) (
    input  logic [C_LEN_WIDTH-1:0]           offset,
    input  logic [C_LEN_WIDTH-1:0]           pkt_len,
    input  logic [47:0]                      dst_mac,
    input  logic [47:0]                      src_mac,
    input  logic [15:0]                      ethertype,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]   tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0] tstrb
);

    localparam int unsigned Bytes = C_M_AXIS_DATA_WIDTH / 8;

    // Each lane carries frame byte offset+i; lanes past the frame length are zero and disabled.
    always_comb begin
        tdata = '0;
        tstrb = '0;
        for (int unsigned i = 0; i < Bytes; i++) begin
            if (32'(offset) + i < 32'(pkt_len)) begin
                tdata[8*i +: 8] = frame_byte(32'(offset) + i, dst_mac, src_mac, ethertype);
                tstrb[i]        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nf10_axis_pkt_gen.sv
// AXI4-Stream Ethernet frame generator with programmable length, frame count and gap.
module nf10_axis_pkt_gen
    import nf10_axis_pkt_gen_pkg::*;
#(
    parameter int unsigned C_M_AXIS_DATA_WIDTH  = 64,
    parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned C_LEN_WIDTH          = 16
) (
    input  logic                              axi_aclk,
    input  logic                              axi_reset,
    input  logic                              start,
    input  logic                              stop,
    input  logic [47:0]                       cfg_dst_mac,
    input  logic [47:0]                       cfg_src_mac,
    input  logic [15:0]                       cfg_ethertype,
    input  logic [C_LEN_WIDTH-1:0]            cfg_pkt_len,
    input  logic [7:0]                        cfg_gap,
    input  logic [15:0]                       cfg_num_pkts,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              busy,
    output logic [31:0]                       pkt_count
);

    localparam int unsigned Bytes = C_M_AXIS_DATA_WIDTH / 8;

    state_e                  state_q, state_d;
    logic [C_LEN_WIDTH-1:0]  offset_q, offset_d;
    logic [15:0]             run_q, run_d;
    logic [7:0]              gap_cnt_q, gap_cnt_d;
    logic                    stop_q, stop_d;
    logic [31:0]             pkt_count_q, pkt_count_d;
    logic                    load_cfg;

    logic [47:0]             da_q, sa_q;
    logic [15:0]             type_q;
    logic [C_LEN_WIDTH-1:0]  len_q;
    logic [7:0]              gap_q;
    logic [15:0]             num_q;
    logic [C_LEN_WIDTH-1:0]  len_clamped;

    logic                    last_beat;
    logic                    stop_seen;
    logic [C_M_AXIS_DATA_WIDTH-1:0]   lane_data;
    logic [C_M_AXIS_DATA_WIDTH/8-1:0] lane_strb;

    assign len_clamped = (cfg_pkt_len < C_LEN_WIDTH'(MinFrameLen)) ?
                         C_LEN_WIDTH'(MinFrameLen) : cfg_pkt_len;
    assign last_beat   = (32'(offset_q) + Bytes) >= 32'(len_q);
    // A stop raised in the deciding cycle counts as already seen.
    assign stop_seen   = stop_q | stop;

    nf10_axis_pkt_gen_lanes #(
        .C_M_AXIS_DATA_WIDTH (C_M_AXIS_DATA_WIDTH),
        .C_LEN_WIDTH         (C_LEN_WIDTH)
    ) u_lanes (
        .offset    (offset_q),
        .pkt_len   (len_q),
        .dst_mac   (da_q),
        .src_mac   (sa_q),
        .ethertype (type_q),
        .tdata     (lane_data),
        .tstrb     (lane_strb)
    );

    // Next-state logic: frame sequencing, run/gap counting and sticky stop.
    always_comb begin
        state_d     = state_q;
        offset_d    = offset_q;
        run_d       = run_q;
        gap_cnt_d   = gap_cnt_q;
        stop_d      = stop_q;
        pkt_count_d = pkt_count_q;
        load_cfg    = 1'b0;
        unique case (state_q)
            StIdle: begin
                stop_d = 1'b0;
                if (start) begin
                    load_cfg = 1'b1;
                    run_d    = '0;
                    offset_d = '0;
                    stop_d   = stop;
                    state_d  = StSend;
                end
            end
            StSend: begin
                stop_d = stop_seen;
                if (m_axis_tready) begin
                    if (last_beat) begin
                        pkt_count_d = pkt_count_q + 32'd1;
                        run_d       = run_q + 16'd1;
                        offset_d    = '0;
                        if (((num_q != 16'd0) && (run_q + 16'd1 == num_q)) || stop_seen) begin
                            state_d = StIdle;
                        end else if (gap_q == 8'd0) begin
                            state_d = StSend;
                        end else begin
                            state_d   = StGap;
                            gap_cnt_d = gap_q;
                        end
                    end else begin
                        offset_d = offset_q + C_LEN_WIDTH'(Bytes);
                    end
                end
            end
            StGap: begin
                stop_d = stop_seen;
                if (gap_cnt_q == 8'd1) begin
                    state_d = stop_seen ? StIdle : StSend;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state registers.
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state_q     <= StIdle;
            offset_q    <= '0;
            run_q       <= '0;
            gap_cnt_q   <= '0;
            stop_q      <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            offset_q    <= offset_d;
            run_q       <= run_d;
            gap_cnt_q   <= gap_cnt_d;
            stop_q      <= stop_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    // Shadow configuration, captured only when a run starts.
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            da_q   <= '0;
            sa_q   <= '0;
            type_q <= '0;
            len_q  <= '0;
            gap_q  <= '0;
            num_q  <= '0;
        end else if (load_cfg) begin
            da_q   <= cfg_dst_mac;
            sa_q   <= cfg_src_mac;
            type_q <= cfg_ethertype;
            len_q  <= len_clamped;
            gap_q  <= cfg_gap;
            num_q  <= cfg_num_pkts;
        end
    end

    // Outputs decode registered state only; everything is zero outside SEND.
    always_comb begin
        m_axis_tvalid = (state_q == StSend);
        m_axis_tdata  = m_axis_tvalid ? lane_data : '0;
        m_axis_tstrb  = m_axis_tvalid ? lane_strb : '0;
        m_axis_tlast  = m_axis_tvalid & last_beat;
        m_axis_tuser  = '0;
        if (m_axis_tvalid && (offset_q == '0)) begin
            m_axis_tuser[15:0] = 16'(len_q);
        end
        busy      = (state_q != StIdle);
        pkt_count = pkt_count_q;
    end

endmodule

// File: tb/tb_nf10_axis_pkt_gen.sv
// Directed self-checking bench for nf10_axis_pkt_gen (64-bit main instance, 256/32-bit side ones).
module tb_nf10_axis_pkt_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        start_w = 1'b0;
    logic        stop = 1'b0;
    logic        tready = 1'b1;
    logic [47:0] cfg_dst_mac = 48'hCAFECAFECAFE;
    logic [47:0] cfg_src_mac = 48'hBEEFBEEFBEEF;
    logic [15:0] cfg_ethertype = 16'h0800;
    logic [15:0] cfg_pkt_len = 16'd64;
    logic [7:0]  cfg_gap = 8'd0;
    logic [15:0] cfg_num_pkts = 16'd1;

    logic [63:0]  tdata;
    logic [7:0]   tstrb;
    logic         tvalid, tlast, busy;
    logic [127:0] tuser;
    logic [31:0]  pkt_count;

    logic [255:0] w_tdata;
    logic [31:0]  w_tstrb;
    logic         w_tvalid, w_tlast, w_busy;
    logic [127:0] w_tuser;
    logic [31:0]  w_pkt_count;

    logic [31:0]  n_tdata;
    logic [3:0]   n_tstrb;
    logic         n_tvalid, n_tlast, n_busy;
    logic [127:0] n_tuser;
    logic [31:0]  n_pkt_count;

    int pass_cnt = 0;
    int tot_cnt = 0;

    // Capture results of the main instance.
    logic [63:0] bd[$];
    logic [7:0]  bs[$];
    logic        bl[$];
    logic [15:0] bu[$];
    int          gaps[$];
    int          n_last, stall_err, last_tlast_cyc, end_cyc;
    bit          timed_out;

    always #5 clk = ~clk;

    nf10_axis_pkt_gen #(
        .C_M_AXIS_DATA_WIDTH(64), .C_M_AXIS_TUSER_WIDTH(128), .C_LEN_WIDTH(16)
    ) dut (
        .axi_aclk(clk), .axi_reset(reset), .start(start), .stop(stop),
        .cfg_dst_mac(cfg_dst_mac), .cfg_src_mac(cfg_src_mac), .cfg_ethertype(cfg_ethertype),
        .cfg_pkt_len(cfg_pkt_len), .cfg_gap(cfg_gap), .cfg_num_pkts(cfg_num_pkts),
        .m_axis_tdata(tdata), .m_axis_tstrb(tstrb), .m_axis_tvalid(tvalid),
        .m_axis_tready(tready), .m_axis_tlast(tlast), .m_axis_tuser(tuser),
        .busy(busy), .pkt_count(pkt_count)
    );

    nf10_axis_pkt_gen #(
        .C_M_AXIS_DATA_WIDTH(256), .C_M_AXIS_TUSER_WIDTH(128), .C_LEN_WIDTH(16)
    ) dut_w256 (
        .axi_aclk(clk), .axi_reset(reset), .start(start_w), .stop(1'b0),
        .cfg_dst_mac(cfg_dst_mac), .cfg_src_mac(cfg_src_mac), .cfg_ethertype(cfg_ethertype),
        .cfg_pkt_len(cfg_pkt_len), .cfg_gap(cfg_gap), .cfg_num_pkts(cfg_num_pkts),
        .m_axis_tdata(w_tdata), .m_axis_tstrb(w_tstrb), .m_axis_tvalid(w_tvalid),
        .m_axis_tready(1'b1), .m_axis_tlast(w_tlast), .m_axis_tuser(w_tuser),
        .busy(w_busy), .pkt_count(w_pkt_count)
    );

    nf10_axis_pkt_gen #(
        .C_M_AXIS_DATA_WIDTH(32), .C_M_AXIS_TUSER_WIDTH(128), .C_LEN_WIDTH(16)
    ) dut_w32 (
        .axi_aclk(clk), .axi_reset(reset), .start(start_w), .stop(1'b0),
        .cfg_dst_mac(cfg_dst_mac), .cfg_src_mac(cfg_src_mac), .cfg_ethertype(cfg_ethertype),
        .cfg_pkt_len(cfg_pkt_len), .cfg_gap(cfg_gap), .cfg_num_pkts(cfg_num_pkts),
        .m_axis_tdata(n_tdata), .m_axis_tstrb(n_tstrb), .m_axis_tvalid(n_tvalid),
        .m_axis_tready(1'b1), .m_axis_tlast(n_tlast), .m_axis_tuser(n_tuser),
        .busy(n_busy), .pkt_count(n_pkt_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Runs the main instance until busy drops, logging accepted beats, gaps and stall violations.
    task automatic capture(input int max_cyc, input bit rnd, input int stop_at);
        logic        prev_stall = 1'b0;
        logic [63:0] pd = '0;
        logic [7:0]  ps = '0;
        logic        pl = 1'b0;
        logic [15:0] pu = '0;
        bit          after_last = 1'b0;
        int          gap_run = 0;
        int          cyc = 0;
        bd.delete(); bs.delete(); bl.delete(); bu.delete(); gaps.delete();
        n_last = 0; stall_err = 0; last_tlast_cyc = -1; end_cyc = -1;
        while (cyc < max_cyc && busy) begin
            tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            stop = (stop_at >= 0 && bd.size() == stop_at && tvalid) ? 1'b1 : 1'b0;
            if (prev_stall && (!tvalid || tdata !== pd || tstrb !== ps || tlast !== pl ||
                               tuser[15:0] !== pu)) begin
                stall_err++;
            end
            if (tvalid && after_last) begin
                gaps.push_back(gap_run);
                after_last = 1'b0;
            end
            if (!tvalid && after_last) gap_run++;
            if (tvalid && tready) begin
                bd.push_back(tdata); bs.push_back(tstrb);
                bl.push_back(tlast); bu.push_back(tuser[15:0]);
                if (tlast) begin
                    n_last++;
                    last_tlast_cyc = cyc;
                    after_last = 1'b1;
                    gap_run = 0;
                end
            end
            prev_stall = tvalid && !tready;
            pd = tdata; ps = tstrb; pl = tlast; pu = tuser[15:0];
            step();
            cyc++;
        end
        stop = 1'b0;
        tready = 1'b1;
        end_cyc = cyc;
        timed_out = busy;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        tot_cnt++; if (tvalid !== 1'b0) $display("FAIL reset_tvalid got %b want 0", tvalid); else pass_cnt++;
        tot_cnt++; if (tlast !== 1'b0) $display("FAIL reset_tlast got %b want 0", tlast); else pass_cnt++;
        tot_cnt++; if (tdata !== 64'h0) $display("FAIL reset_tdata got %h want 0", tdata); else pass_cnt++;
        tot_cnt++; if (tstrb !== 8'h0) $display("FAIL reset_tstrb got %h want 0", tstrb); else pass_cnt++;
        tot_cnt++; if (tuser !== 128'h0) $display("FAIL reset_tuser got %h want 0", tuser); else pass_cnt++;
        tot_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
        tot_cnt++; if (pkt_count !== 32'd0) $display("FAIL reset_pkt_count got %0d want 0", pkt_count); else pass_cnt++;
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        cfg_pkt_len = 16'd64; cfg_num_pkts = 16'd1; cfg_gap = 8'd0;
        pulse_start();
        tot_cnt++; if (tvalid !== 1'b1 || busy !== 1'b1) $display("FAIL start_latency got valid=%b busy=%b want 1 1", tvalid, busy); else pass_cnt++;
        capture(200, 1'b0, -1);
        tot_cnt++; if (timed_out) $display("FAIL basic_timeout got busy=1 want 0"); else pass_cnt++;
        tot_cnt++; if (bd.size() != 8) $display("FAIL basic_beats got %0d want 8", bd.size()); else pass_cnt++;
        if (bd.size() == 8) begin
            tot_cnt++; if (bd[0] !== 64'hEFBEFECAFECAFECA) $display("FAIL basic_beat0 got %h want EFBEFECAFECAFECA", bd[0]); else pass_cnt++;
            tot_cnt++; if (bd[1] !== 64'h01000008EFBEEFBE) $display("FAIL basic_beat1 got %h want 01000008EFBEEFBE", bd[1]); else pass_cnt++;
            tot_cnt++; if (bd[2] !== 64'h0908070605040302) $display("FAIL basic_beat2 got %h want 0908070605040302", bd[2]); else pass_cnt++;
            tot_cnt++; if (bd[7] !== 64'h31302F2E2D2C2B2A) $display("FAIL basic_beat7 got %h want 31302F2E2D2C2B2A", bd[7]); else pass_cnt++;
            tot_cnt++; if (bl[7] !== 1'b1 || n_last != 1) $display("FAIL basic_tlast got last7=%b n=%0d want 1 1", bl[7], n_last); else pass_cnt++;
            tot_cnt++; if (bs[7] !== 8'hFF) $display("FAIL basic_last_strb got %h want FF", bs[7]); else pass_cnt++;
            tot_cnt++; if (bu[0] !== 16'd64) $display("FAIL basic_tuser0 got %0d want 64", bu[0]); else pass_cnt++;
            tot_cnt++; if (bu[1] !== 16'd0) $display("FAIL basic_tuser1 got %0d want 0", bu[1]); else pass_cnt++;
        end
        tot_cnt++; if (pkt_count !== 32'd1) $display("FAIL basic_pkt_count got %0d want 1", pkt_count); else pass_cnt++;
        tot_cnt++; if (end_cyc != last_tlast_cyc + 1) $display("FAIL basic_busy_fall got cyc %0d want %0d", end_cyc, last_tlast_cyc + 1); else pass_cnt++;
    endtask

    task automatic test_short_len();
        cfg_pkt_len = 16'd61; cfg_num_pkts = 16'd1; cfg_gap = 8'd0;
        pulse_start();
        capture(200, 1'b0, -1);
        tot_cnt++; if (bd.size() != 8) $display("FAIL len61_beats got %0d want 8", bd.size()); else pass_cnt++;
        if (bd.size() == 8) begin
            tot_cnt++; if (bs[7] !== 8'h1F) $display("FAIL len61_strb got %h want 1F", bs[7]); else pass_cnt++;
            tot_cnt++; if (bd[7] !== 64'h0000002E2D2C2B2A) $display("FAIL len61_data got %h want 0000002E2D2C2B2A", bd[7]); else pass_cnt++;
            tot_cnt++; if (bs[6] !== 8'hFF) $display("FAIL len61_strb6 got %h want FF", bs[6]); else pass_cnt++;
        end
        cfg_pkt_len = 16'd40;
        pulse_start();
        capture(200, 1'b0, -1);
        tot_cnt++; if (bd.size() != 8) $display("FAIL len40_beats got %0d want 8", bd.size()); else pass_cnt++;
        if (bd.size() == 8) begin
            tot_cnt++; if (bu[0] !== 16'd60) $display("FAIL len40_tuser got %0d want 60", bu[0]); else pass_cnt++;
            tot_cnt++; if (bs[7] !== 8'h0F) $display("FAIL len40_strb got %h want 0F", bs[7]); else pass_cnt++;
            tot_cnt++; if (bd[7] !== 64'h000000002D2C2B2A) $display("FAIL len40_data got %h want 000000002D2C2B2A", bd[7]); else pass_cnt++;
        end
        tot_cnt++; if (pkt_count !== 32'd3) $display("FAIL len_pkt_count got %0d want 3", pkt_count); else pass_cnt++;
    endtask

    task automatic test_widths();
        int          w_beats = 0;
        int          n_beats = 0;
        int          n_bad_strb = 0;
        int          n_last_idx = -1;
        int          cyc = 0;
        logic [31:0] w_strb0 = '0;
        logic [31:0] w_strb1 = '0;
        cfg_pkt_len = 16'd60; cfg_num_pkts = 16'd1; cfg_gap = 8'd0;
        start_w = 1'b1;
        step();
        start_w = 1'b0;
        while (cyc < 100 && (w_busy || n_busy)) begin
            if (w_tvalid) begin
                if (w_beats == 0) w_strb0 = w_tstrb;
                if (w_beats == 1) w_strb1 = w_tstrb;
                w_beats++;
            end
            if (n_tvalid) begin
                if (n_tstrb !== 4'hF) n_bad_strb++;
                if (n_tlast) n_last_idx = n_beats;
                n_beats++;
            end
            step();
            cyc++;
        end
        tot_cnt++; if (w_beats != 2) $display("FAIL w256_beats got %0d want 2", w_beats); else pass_cnt++;
        tot_cnt++; if (w_strb0 !== 32'hFFFFFFFF) $display("FAIL w256_strb0 got %h want FFFFFFFF", w_strb0); else pass_cnt++;
        tot_cnt++; if (w_strb1 !== 32'h0FFFFFFF) $display("FAIL w256_strb1 got %h want 0FFFFFFF", w_strb1); else pass_cnt++;
        tot_cnt++; if (n_beats != 15) $display("FAIL w32_beats got %0d want 15", n_beats); else pass_cnt++;
        tot_cnt++; if (n_bad_strb != 0) $display("FAIL w32_strb got %0d partial beats want 0", n_bad_strb); else pass_cnt++;
        tot_cnt++; if (n_last_idx != 14) $display("FAIL w32_tlast got beat %0d want 14", n_last_idx); else pass_cnt++;
    endtask

    task automatic test_gap_backpressure();
        reset = 1'b1;
        step();
        reset = 1'b0;
        cfg_pkt_len = 16'd64; cfg_num_pkts = 16'd3; cfg_gap = 8'd5;
        pulse_start();
        capture(1000, 1'b1, -1);
        tot_cnt++; if (timed_out) $display("FAIL gap_timeout got busy=1 want 0"); else pass_cnt++;
        tot_cnt++; if (n_last != 3) $display("FAIL gap_tlast_count got %0d want 3", n_last); else pass_cnt++;
        tot_cnt++; if (bd.size() != 24) $display("FAIL gap_beats got %0d want 24", bd.size()); else pass_cnt++;
        tot_cnt++; if (pkt_count !== 32'd3) $display("FAIL gap_pkt_count got %0d want 3", pkt_count); else pass_cnt++;
        tot_cnt++; if (stall_err != 0) $display("FAIL gap_stall_stable got %0d violations want 0", stall_err); else pass_cnt++;
        tot_cnt++; if (gaps.size() != 2) $display("FAIL gap_count got %0d want 2", gaps.size()); else pass_cnt++;
        if (gaps.size() == 2) begin
            tot_cnt++; if (gaps[0] != 5 || gaps[1] != 5) $display("FAIL gap_len got %0d,%0d want 5,5", gaps[0], gaps[1]); else pass_cnt++;
        end
        if (bd.size() == 24) begin
            tot_cnt++; if (bd[8] !== 64'hEFBEFECAFECAFECA) $display("FAIL gap_f2_beat0 got %h want EFBEFECAFECAFECA", bd[8]); else pass_cnt++;
            tot_cnt++; if (bu[16] !== 16'd64) $display("FAIL gap_f3_tuser got %0d want 64", bu[16]); else pass_cnt++;
        end
    endtask

    task automatic test_stop();
        reset = 1'b1;
        step();
        reset = 1'b0;
        cfg_pkt_len = 16'd64; cfg_num_pkts = 16'd0; cfg_gap = 8'd0;
        pulse_start();
        capture(500, 1'b0, 11);
        tot_cnt++; if (timed_out) $display("FAIL stop_timeout got busy=1 want 0"); else pass_cnt++;
        tot_cnt++; if (n_last != 2) $display("FAIL stop_tlast_count got %0d want 2", n_last); else pass_cnt++;
        tot_cnt++; if (bd.size() != 16) $display("FAIL stop_beats got %0d want 16", bd.size()); else pass_cnt++;
        tot_cnt++; if (gaps.size() != 1 || (gaps.size() == 1 && gaps[0] != 0)) $display("FAIL stop_no_bubble got %0d gaps want one of 0", gaps.size()); else pass_cnt++;
        tot_cnt++; if (pkt_count !== 32'd2) $display("FAIL stop_pkt_count got %0d want 2", pkt_count); else pass_cnt++;
        // start and stop together in IDLE yields exactly one frame
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        capture(500, 1'b0, -1);
        tot_cnt++; if (n_last != 1 || bd.size() != 8) $display("FAIL start_stop got %0d frames %0d beats want 1 8", n_last, bd.size()); else pass_cnt++;
        tot_cnt++; if (pkt_count !== 32'd3) $display("FAIL start_stop_pkt_count got %0d want 3", pkt_count); else pass_cnt++;
        // start while busy is ignored: one-frame run with a second start mid-frame
        cfg_num_pkts = 16'd1;
        pulse_start();
        step();
        pulse_start();
        capture(500, 1'b0, -1);
        tot_cnt++; if (pkt_count !== 32'd4) $display("FAIL start_busy_ignored got %0d want 4", pkt_count); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        cfg_pkt_len = 16'd64; cfg_num_pkts = 16'd0; cfg_gap = 8'd0;
        pulse_start();
        repeat (4) step();
        tot_cnt++; if (tvalid !== 1'b1) $display("FAIL mid_before_valid got %b want 1", tvalid); else pass_cnt++;
        tot_cnt++; if (pkt_count !== 32'd4) $display("FAIL mid_before_count got %0d want 4", pkt_count); else pass_cnt++;
        reset = 1'b1;
        step();
        tot_cnt++; if (tvalid !== 1'b0) $display("FAIL mid_reset_tvalid got %b want 0", tvalid); else pass_cnt++;
        tot_cnt++; if (pkt_count !== 32'd0) $display("FAIL mid_reset_pkt_count got %0d want 0", pkt_count); else pass_cnt++;
        tot_cnt++; if (busy !== 1'b0) $display("FAIL mid_reset_busy got %b want 0", busy); else pass_cnt++;
        reset = 1'b0;
        repeat (3) step();
        tot_cnt++; if (tvalid !== 1'b0) $display("FAIL mid_stays_idle got %b want 0", tvalid); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short_len();
        test_widths();
        test_gap_backpressure();
        test_stop();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
